cpu_ext_trace_capture: RTL



---
 rtl/cpu_ext_trace_pkg.sv | 16 +
 rtl/cpu_ext_trace_fifo.sv | 78 +++++++
 rtl/cpu_ext_trace_capture.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_ext_trace_pkg.sv
// Shared constants and types for the off-chip trace capture path.
package cpu_ext_trace_pkg;

    localparam int               DEF_TRACE_W   = 18;
    localparam logic [17:0]      DEF_SYNC_WORD = 18'h3FFFF;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    function automatic int word_w(input int trace_w);
        return 2 * trace_w;
    endfunction

endpackage

// File: rtl/cpu_ext_trace_fifo.sv
// First-word-fall-through FIFO; occupancy counter separates full from empty.
module cpu_ext_trace_fifo #(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;

    // A pop request on an empty FIFO is ignored even when a push lands.
    assign pop_ok  = pop && rd_valid;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cpu_ext_trace_capture.sv
// Trace-lane receiver: SYNC hunt, beat-pair packing, FWFT buffering, status.
//   state     | meaning
//   ST_HUNT   | discarding beats until a SYNC word is seen
//   ST_LOCKED | aligned; packing beat pairs into words
module cpu_ext_trace_capture
    import cpu_ext_trace_pkg::*;
#(
    parameter  int                 TRACE_W    = DEF_TRACE_W,
    parameter  int                 FIFO_DEPTH = 16,
    parameter  logic [TRACE_W-1:0] SYNC_WORD  = TRACE_W'(DEF_SYNC_WORD),
    parameter  int                 OVF_W      = 8,
    localparam int                 WORD_W     = word_w(TRACE_W),
    localparam int                 LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               tr_valid,
    input  logic [TRACE_W-1:0] tr_data,
    output logic               rd_valid,
    output logic [WORD_W-1:0]  rd_data,
    input  logic               rd_ready,
    output logic               locked,
    output logic               align_err,
    output logic [OVF_W-1:0]   ovf_cnt,
    output logic [LVL_W-1:0]   fifo_level
);

    lock_state_e        state_q, state_d;
    logic               phase_q, phase_d;
    logic [TRACE_W-1:0] held_q, held_d;
    logic               align_err_q, align_err_d;
    logic [OVF_W-1:0]   ovf_cnt_q, ovf_cnt_d;

    logic               fifo_push;
    logic [WORD_W-1:0]  fifo_wdata;
    logic               fifo_pop;
    logic               fifo_full;
    logic               beat_sync;

    assign beat_sync = (tr_data == SYNC_WORD);
    assign fifo_pop  = rd_valid && rd_ready && !clr;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        held_d      = held_q;
        align_err_d = align_err_q;
        ovf_cnt_d   = ovf_cnt_q;
        fifo_push   = 1'b0;
        fifo_wdata  = {tr_data, held_q};
        if (clr) begin
            state_d     = ST_HUNT;
            phase_d     = 1'b0;
            held_d      = '0;
            align_err_d = 1'b0;
            ovf_cnt_d   = '0;
        end else if (tr_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (beat_sync) begin
                        state_d = ST_LOCKED;
                        phase_d = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (beat_sync) begin
                        if (phase_q) begin
                            align_err_d = 1'b1;
                            phase_d     = 1'b0;
                            held_d      = '0;
                        end
                    end else if (!phase_q) begin
                        held_d  = tr_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // Full FIFO still accepts when the head leaves this cycle.
                        if (!fifo_full || fifo_pop) begin
                            fifo_push = 1'b1;
                        end else if (ovf_cnt_q != '1) begin
                            ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            phase_q     <= 1'b0;
            held_q      <= '0;
            align_err_q <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            held_q      <= held_d;
            align_err_q <= align_err_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign align_err = align_err_q;
    assign ovf_cnt   = ovf_cnt_q;

    cpu_ext_trace_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (clr),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .level     (fifo_level)
    );

endmodule
